// File: rtl/pid_pwm_hbridge.sv
// pid_pwm_hbridge: sign-magnitude H-bridge PWM with period-aligned duty updates and reversal dead time
module pid_pwm_hbridge #(
  parameter int ow = 12,
  parameter int dt = 16
) (
  input  logic          clk_pid,
  input  logic          reset,
  input  logic          ce,
  input  logic [ow-1:0] power,
  input  logic          enable,
  output logic          pwm_a,
  output logic          pwm_b,
  output logic          dir,
  output logic          period_sync
);
  localparam int cw = ow - 1;
  typedef enum logic {RUN, DEAD} state_t;
  state_t state_q, state_d;
  logic [cw-1:0] cnt_q, duty_q, duty_d, pend_mag_q, pend_mag_d, dt_cnt_q, dt_cnt_d, mag;
  logic [ow-1:0] neg;
  logic pend_sign_q, pend_sign_d, pend_valid_q, pend_valid_d, dir_q, dir_d, wrap, reverse;
  assign neg = -power;
  // -2^(ow-1) negates to itself; its top bit flags the one value that must saturate
  assign mag = !power[ow-1] ? power[cw-1:0] : neg[ow-1] ? '1 : neg[cw-1:0];
  assign wrap = &cnt_q;
  assign reverse = (pend_mag_q != '0) && (pend_sign_q != dir_q);
  assign dir = dir_q;
  assign period_sync = wrap;
  always_comb begin
    state_d = state_q;
    duty_d = duty_q;
    dir_d = dir_q;
    dt_cnt_d = (state_q == DEAD && dt_cnt_q != '0) ? dt_cnt_q - 1'b1 : dt_cnt_q;
    pend_mag_d = ce ? mag : pend_mag_q;
    pend_sign_d = ce ? power[ow-1] : pend_sign_q;
    pend_valid_d = pend_valid_q;
    if (wrap && state_q == RUN && pend_valid_q) begin
      pend_valid_d = 1'b0;
      state_d = reverse ? DEAD : RUN;
      duty_d = reverse ? '0 : pend_mag_q;
      dt_cnt_d = reverse ? cw'(dt) : dt_cnt_d;
    end else if (wrap && state_q == DEAD && dt_cnt_q == '0) begin
      pend_valid_d = 1'b0;
      state_d = RUN;
      duty_d = pend_mag_q;
      dir_d = (pend_mag_q != '0) ? pend_sign_q : dir_q;
    end
    if (ce) pend_valid_d = 1'b1;
  end
  always_ff @(posedge clk_pid or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q <= '0;
      duty_q <= '0;
      dt_cnt_q <= '0;
      pend_mag_q <= '0;
      pend_sign_q <= 1'b0;
      pend_valid_q <= 1'b0;
      dir_q <= 1'b0;
      pwm_a <= 1'b0;
      pwm_b <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_q + 1'b1;
      duty_q <= duty_d;
      dt_cnt_q <= dt_cnt_d;
      pend_mag_q <= pend_mag_d;
      pend_sign_q <= pend_sign_d;
      pend_valid_q <= pend_valid_d;
      dir_q <= dir_d;
      pwm_a <= enable && state_q == RUN && cnt_q < duty_q && !dir_q;
      pwm_b <= enable && state_q == RUN && cnt_q < duty_q && dir_q;
    end
  end
endmodule

// File: tb/tb_pid_pwm_hbridge.sv
// tb_pid_pwm_hbridge: period-level reference model of the H-bridge PWM against randomized and directed ce traffic
module tb_pid_pwm_hbridge;
  localparam int OW = 6, DT = 4, N = 32;
  logic clk = 1'b0, reset = 1'b1, ce = 1'b0, enable = 1'b1;
  logic [OW-1:0] power = '0;
  logic pwm_a, pwm_b, dir, period_sync;
  int checks = 0, errors = 0;
  int m_duty, m_dir, m_dead, p_mag, p_sign, p_valid;
  int q_pos[$], q_val[$];
  int ca, cb, bad, ea, eb;
  logic d0;
  bit ed;

  pid_pwm_hbridge #(.ow(OW), .dt(DT)) dut (
    .clk_pid(clk), .reset(reset), .ce(ce), .power(power), .enable(enable),
    .pwm_a(pwm_a), .pwm_b(pwm_b), .dir(dir), .period_sync(period_sync)
  );

  always #5 clk = ~clk;

  function automatic int mag_of(int p);
    int a = p < 0 ? -p : p;
    return a > N - 1 ? N - 1 : a;
  endfunction

  task automatic model_reset;
    m_duty = 0; m_dir = 0; m_dead = 0; p_mag = 0; p_sign = 0; p_valid = 0;
  endtask

  task automatic model_ce(input int p);
    p_mag = mag_of(p); p_sign = p < 0 ? 1 : 0; p_valid = 1;
  endtask

  // dt < N, so a reversal always blanks exactly one whole period
  task automatic model_boundary;
    if (m_dead != 0) begin
      if (p_mag != 0) m_dir = p_sign;
      m_duty = p_mag; p_valid = 0; m_dead = 0;
    end else if (p_valid != 0) begin
      if (p_mag != 0 && p_sign != m_dir) begin m_dead = 1; m_duty = 0; end
      else m_duty = p_mag;
      p_valid = 0;
    end
  endtask

  task automatic set_exp(input bit en);
    ea = (en && m_dead == 0 && m_dir == 0) ? m_duty : 0;
    eb = (en && m_dead == 0 && m_dir == 1) ? m_duty : 0;
    ed = m_dir[0];
  endtask

  // entered and left on the falling edge where the counter reads 0
  task automatic run_period(input bit en);
    ca = 0; cb = 0; bad = 0; d0 = dir;
    enable = en;
    for (int i = 0; i < N; i++) begin
      if (pwm_a === 1'b1) ca++;
      if (pwm_b === 1'b1) cb++;
      if (pwm_a === 1'b1 && pwm_b === 1'b1) bad++;
      if (period_sync !== (i == N - 1)) bad++;
      ce = 1'b0;
      foreach (q_pos[k]) if (q_pos[k] == i) begin
        ce = 1'b1; power = OW'(q_val[k]); model_ce(q_val[k]);
      end
      @(negedge clk);
    end
    ce = 1'b0;
    q_pos.delete(); q_val.delete();
    model_boundary();
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({pwm_a, pwm_b, dir, period_sync} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs: got %b%b%b%b expected 0000", pwm_a, pwm_b, dir, period_sync);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int p = 0; p < 2; p++) begin
      set_exp(1); run_period(1);
      checks++;
      if (ca !== 0 || cb !== 0 || d0 !== 1'b0 || bad !== 0) begin
        errors++; $display("FAIL reset_idle p%0d: a=%0d b=%0d dir=%b bad=%0d expected 0 0 0 0", p, ca, cb, d0, bad);
      end
    end
  endtask

  task automatic test_directed(input string name, input int vals[$], input int periods);
    for (int p = 0; p < periods; p++) begin
      if (p < vals.size()) begin q_pos.push_back(int'($urandom_range(0, 30))); q_val.push_back(vals[p]); end
      set_exp(1); run_period(1);
      checks++;
      if (ca !== ea || cb !== eb || d0 !== ed || bad !== 0) begin
        errors++;
        $display("FAIL %s p%0d: a=%0d b=%0d dir=%b bad=%0d expected a=%0d b=%0d dir=%b bad=0", name, p, ca, cb, d0, bad, ea, eb, ed);
      end
    end
  endtask

  task automatic test_last_wins;
    q_pos = '{3, 20}; q_val = '{5, 12};
    for (int p = 0; p < 4; p++) begin
      if (p == 2) begin q_pos = '{10}; q_val = '{0}; end
      set_exp(1); run_period(1);
      checks++;
      if (ca !== ea || cb !== eb || d0 !== ed || bad !== 0) begin
        errors++; $display("FAIL last_wins p%0d: a=%0d b=%0d dir=%b expected a=%0d b=%0d dir=%b", p, ca, cb, d0, ea, eb, ed);
      end
    end
    checks++;
    if (ca !== 0 || cb !== 0) begin
      errors++; $display("FAIL zero_power: a=%0d b=%0d expected 0 0", ca, cb);
    end
  endtask

  task automatic test_dead_restore;
    q_pos = '{4}; q_val = '{20};
    for (int p = 0; p < 6; p++) begin
      if (p == 2) begin q_pos = '{7}; q_val = '{-8}; end
      if (p == 3) begin q_pos = '{15}; q_val = '{15}; end
      set_exp(1); run_period(1);
      checks++;
      if (ca !== ea || cb !== eb || d0 !== ed || bad !== 0) begin
        errors++; $display("FAIL dead_restore p%0d: a=%0d b=%0d dir=%b expected a=%0d b=%0d dir=%b", p, ca, cb, d0, ea, eb, ed);
      end
    end
    checks++;
    if (ca !== 15 || d0 !== 1'b0) begin
      errors++; $display("FAIL dead_restore_final: a=%0d dir=%b expected 15 0", ca, d0);
    end
  endtask

  task automatic test_enable;
    for (int p = 0; p < 3; p++) begin
      set_exp(p != 1); run_period(p != 1);
      checks++;
      if (ca !== ea || cb !== eb || bad !== 0) begin
        errors++; $display("FAIL enable p%0d: a=%0d b=%0d expected a=%0d b=%0d", p, ca, cb, ea, eb);
      end
    end
  endtask

  task automatic test_random;
    bit en;
    for (int p = 0; p < 30; p++) begin
      for (int k = int'($urandom_range(0, 2)); k > 0; k--) begin
        q_pos.push_back(int'($urandom_range(0, 30)));
        q_val.push_back(int'($urandom_range(0, 63)) - 32);
      end
      en = $urandom_range(0, 4) != 0;
      set_exp(en); run_period(en);
      checks++;
      if (ca !== ea || cb !== eb || d0 !== ed || bad !== 0) begin
        errors++; $display("FAIL random p%0d: a=%0d b=%0d dir=%b bad=%0d expected a=%0d b=%0d dir=%b", p, ca, cb, d0, bad, ea, eb, ed);
      end
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    test_directed("pre_reset", '{-5, 20}, 4);
    repeat (6) @(negedge clk);
    seen = pwm_a;
    checks++;
    if (seen !== 1 || m_duty !== 20 || m_dir !== 0) begin
      errors++; $display("FAIL pre_reset_drive: pwm_a=%0d duty=%0d dir=%0d expected 1 20 0", seen, m_duty, m_dir);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({pwm_a, pwm_b, dir} !== 3'b000) begin
      errors++; $display("FAIL async_reset: got %b%b%b expected 000", pwm_a, pwm_b, dir);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    test_directed("post_reset", '{}, 2);
    test_directed("post_reset_ce", '{7}, 2);
  endtask

  initial begin
    test_reset();
    test_directed("forward", '{10}, 3);
    test_directed("saturation", '{-31, 0, -32}, 5);
    test_directed("reversal", '{20, 0, -8}, 5);
    test_directed("to_forward", '{3}, 3);
    test_last_wins();
    test_dead_restore();
    test_enable();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
